// File: rtl/mmc1_sx.sv
// MMC1 (SNROM/SOROM/SUROM/SXROM) mapper: serial register load with RMW write filter, outer PRG banking.
// Optional banked PRG-RAM at $6000-$7FFF is built when MMC1_PRG_RAM_EN is defined.
module mmc1_sx #(
   parameter int unsigned ADDR_BITS     = 23,
   parameter int unsigned PRG_ADDR_W    = 19,
   parameter int unsigned CHR_ADDR_W    = 17,
   parameter int unsigned PRG_RAM_BANKS = 4
) (
   input  logic                 m2,
   input  logic                 reset,
   input  logic [15:0]          cpu_addr,
   input  logic [7:0]           cpu_data_in,
   input  logic                 cpu_rw,
   input  logic [13:0]          ppu_addr,
   input  logic                 ppu_rd,
   input  logic                 ppu_wr,
   input  logic                 chr_ram,
   output logic [ADDR_BITS-1:0] prg_addr,
   output logic                 prg_oe,
   output logic                 prg_ram_ce,
   output logic                 prg_ram_we,
   output logic [14:0]          prg_ram_addr,
   output logic [ADDR_BITS-1:0] chr_addr,
   output logic                 chr_ce,
   output logic                 chr_oe,
   output logic                 chr_we,
   output logic                 ciram_ce,
   output logic                 ciram_a10
);

   logic [4:0] shift, control, chr0, chr1, prg;
   logic       last_wr;
   logic       wr_cycle;
   logic [4:0] shift_next;

   assign wr_cycle   = cpu_addr[15] & ~cpu_rw;
   assign shift_next = {cpu_data_in[0], shift[4:1]};

   // last_wr tracks every register write, filtered or not, so RMW dummy writes are dropped
   always_ff @(negedge m2) begin
      if (reset) begin
         shift   <= 5'b10000;
         control <= 5'b01100;
         chr0    <= '0;
         chr1    <= '0;
         prg     <= '0;
         last_wr <= 1'b0;
      end else begin
         last_wr <= wr_cycle;
         if (wr_cycle && !last_wr) begin
            if (cpu_data_in[7]) begin
               shift   <= 5'b10000;
               control <= control | 5'b01100;
            end else if (shift[0]) begin
               case (cpu_addr[14:13])
                  2'd0:    control <= shift_next;
                  2'd1:    chr0    <= shift_next;
                  2'd2:    chr1    <= shift_next;
                  default: prg     <= shift_next;
               endcase
               shift <= 5'b10000;
            end else begin
               shift <= shift_next;
            end
         end
      end
   end

   logic [3:0]           prg_sel;
   logic [18:0]          prg_full;
   logic [ADDR_BITS-1:0] prg_wide;
   logic [4:0]           chr_sel;
   logic [16:0]          chr_full;
   logic [ADDR_BITS-1:0] chr_wide;

   always_comb begin
      prg_sel = {prg[3:1], cpu_addr[14]};
      case (control[3:2])
         2'b10:   prg_sel = cpu_addr[14] ? prg[3:0] : 4'h0;
         2'b11:   prg_sel = cpu_addr[14] ? 4'hF : prg[3:0];
         default: prg_sel = {prg[3:1], cpu_addr[14]};
      endcase
   end

   assign prg_full = {chr0[4], prg_sel, cpu_addr[13:0]};
   assign chr_sel  = control[4] ? (ppu_addr[12] ? chr1 : chr0) : {chr0[4:1], ppu_addr[12]};
   assign chr_full = chr_ram ? {4'b0, ppu_addr[12:0]} : {chr_sel, ppu_addr[11:0]};
   assign prg_wide = ADDR_BITS'(prg_full);
   assign chr_wide = ADDR_BITS'(chr_full);

   // Bits past the implemented widths are zero-filled, never wrapped
   always_comb begin
      prg_addr = '0;
      chr_addr = '0;
      for (int unsigned i = 0; i < ADDR_BITS; i++) begin
         prg_addr[i] = (i < PRG_ADDR_W) ? prg_wide[i] : 1'b0;
         chr_addr[i] = (i < CHR_ADDR_W) ? chr_wide[i] : 1'b0;
      end
   end

   always_comb begin
      case (control[1:0])
         2'd0:    ciram_a10 = 1'b0;
         2'd1:    ciram_a10 = 1'b1;
         2'd2:    ciram_a10 = ppu_addr[10];
         default: ciram_a10 = ppu_addr[11];
      endcase
   end

   assign prg_oe   = cpu_rw & cpu_addr[15];
   assign chr_ce   = ~ppu_addr[13];
   assign ciram_ce = ~ppu_addr[13];
   assign chr_oe   = ~ppu_rd;
   assign chr_we   = chr_ram & ~ppu_wr;

`ifdef MMC1_PRG_RAM_EN
   logic       ram_sel;
   logic [1:0] ram_src;
   logic [1:0] ram_bank;

   assign ram_sel = (cpu_addr[15:13] == 3'b011);
   // Bank follows the CHR select currently latched onto the PPU bus
   assign ram_src = (control[4] && ppu_addr[12]) ? chr1[3:2] : chr0[3:2];

   always_comb begin
      ram_bank = 2'b00;
      if (PRG_RAM_BANKS >= 4)      ram_bank = ram_src;
      else if (PRG_RAM_BANKS == 2) ram_bank = {1'b0, ram_src[1]};
   end

   assign prg_ram_ce   = ram_sel & ~prg[4];
   assign prg_ram_we   = prg_ram_ce & ~cpu_rw;
   assign prg_ram_addr = {ram_bank, cpu_addr[12:0]};
`else
   logic unused_ram_cfg;

   assign unused_ram_cfg = prg[4] ^ (PRG_RAM_BANKS == 0);
   assign prg_ram_ce     = 1'b0;
   assign prg_ram_we     = 1'b0;
   assign prg_ram_addr   = '0;
`endif

endmodule

// File: tb/tb_mmc1_sx.sv
// Bench for mmc1_sx: table-driven bus vectors plus hand-written serial-load corner cases.
// Expected values are queued as stimulus is driven and compared in the m2 high phase.
module tb_mmc1_sx;

   logic        m2 = 1'b1;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_in;
   logic        cpu_rw;
   logic [13:0] ppu_addr;
   logic        ppu_rd;
   logic        ppu_wr;
   logic        chr_ram;
   logic [22:0] prg_addr;
   logic        prg_oe;
   logic        prg_ram_ce;
   logic        prg_ram_we;
   logic [14:0] prg_ram_addr;
   logic [22:0] chr_addr;
   logic        chr_ce;
   logic        chr_oe;
   logic        chr_we;
   logic        ciram_ce;
   logic        ciram_a10;

   mmc1_sx #(
      .ADDR_BITS(23),
      .PRG_ADDR_W(19),
      .CHR_ADDR_W(17),
      .PRG_RAM_BANKS(4)
   ) dut (
      .m2(m2), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
      .cpu_rw(cpu_rw), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_wr(ppu_wr),
      .chr_ram(chr_ram), .prg_addr(prg_addr), .prg_oe(prg_oe),
      .prg_ram_ce(prg_ram_ce), .prg_ram_we(prg_ram_we), .prg_ram_addr(prg_ram_addr),
      .chr_addr(chr_addr), .chr_ce(chr_ce), .chr_oe(chr_oe), .chr_we(chr_we),
      .ciram_ce(ciram_ce), .ciram_a10(ciram_a10)
   );

   always #5 m2 = ~m2;

   localparam int S_PRG = 0, S_A10 = 1, S_CHR = 2, S_RCE = 3, S_RWE = 4,
                  S_RADDR = 5, S_CWE = 6, S_CCE = 7, S_COE = 8, S_POE = 9;

   typedef struct {
      string       name;
      int          sig;
      logic [31:0] exp;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
      logic        rw;
      logic [13:0] pa;
      logic        chk;
      logic [22:0] exp_prg;
      logic        exp_a10;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] actual(input int sig);
      case (sig)
         S_PRG:   return {9'b0, prg_addr};
         S_A10:   return {31'b0, ciram_a10};
         S_CHR:   return {9'b0, chr_addr};
         S_RCE:   return {31'b0, prg_ram_ce};
         S_RWE:   return {31'b0, prg_ram_we};
         S_RADDR: return {17'b0, prg_ram_addr};
         S_CWE:   return {31'b0, chr_we};
         S_CCE:   return {31'b0, chr_ce};
         S_COE:   return {31'b0, chr_oe};
         default: return {31'b0, prg_oe};
      endcase
   endfunction

   task automatic expect_val(input string name, input int sig, input logic [31:0] exp);
      exp_t e;
      e.name = name; e.sig = sig; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         act = actual(e.sig);
         total++;
         if (act !== e.exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
         end
      end
   endtask

   // Drive one bus cycle, compare queued expectations in the high phase, then let the falling edge commit
   task automatic step(input logic [15:0] a, input logic [7:0] d, input logic rw, input logic [13:0] pa);
      cpu_addr = a; cpu_data_in = d; cpu_rw = rw; ppu_addr = pa;
      @(posedge m2); #1;
      drain();
      @(negedge m2); #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic b);
      step(a, {7'b0, b}, 1'b0, 14'h0);
   endtask

   task automatic rd(input logic [15:0] a, input logic [13:0] pa);
      step(a, 8'h00, 1'b1, pa);
   endtask

   task automatic spaced_load(input logic [15:0] a, input logic [4:0] v);
      for (int k = 0; k < 5; k++) begin
         wr(a, v[k]);
         rd(16'h0000, 14'h0);
      end
   endtask

   task automatic tw(input logic [15:0] a, input logic [7:0] d);
      vec_t v;
      v.a = a; v.d = d; v.rw = 1'b0; v.pa = 14'h0; v.chk = 1'b0; v.exp_prg = '0; v.exp_a10 = 1'b0;
      tbl.push_back(v);
   endtask

   task automatic tr(input logic [15:0] a, input logic [13:0] pa, input logic [22:0] ep, input logic ea);
      vec_t v;
      v.a = a; v.d = 8'h00; v.rw = 1'b1; v.pa = pa; v.chk = 1'b1; v.exp_prg = ep; v.exp_a10 = ea;
      tbl.push_back(v);
   endtask

   initial begin
      reset = 1'b1; cpu_addr = 16'h0; cpu_data_in = 8'h0; cpu_rw = 1'b1;
      ppu_addr = 14'h0; ppu_rd = 1'b1; ppu_wr = 1'b1; chr_ram = 1'b0;

      // Reset defaults, PRG=5 via $E000, control=00010 via $8000, then $80 reset write
      tr(16'hC000, 14'h0000, 23'h3C000, 1'b0);
      tr(16'h8000, 14'h0000, 23'h00000, 1'b0);
      tw(16'hE000, 8'h01); tr(16'h8000, 14'h0, 23'h0, 1'b0);
      tw(16'hE000, 8'h00); tr(16'h8000, 14'h0, 23'h0, 1'b0);
      tw(16'hE000, 8'h01); tr(16'h8000, 14'h0, 23'h0, 1'b0);
      tw(16'hE000, 8'h00); tr(16'h8000, 14'h0, 23'h0, 1'b0);
      tw(16'hE000, 8'h00);
      tr(16'h8000, 14'h0000, 23'h14000, 1'b0);
      tr(16'h9234, 14'h0000, 23'h15234, 1'b0);
      tr(16'hC000, 14'h0000, 23'h3C000, 1'b0);
      tw(16'h8000, 8'h00); tr(16'hC000, 14'h0, 23'h3C000, 1'b0);
      tw(16'h8000, 8'h01); tr(16'hC000, 14'h0, 23'h3C000, 1'b0);
      tw(16'h8000, 8'h00); tr(16'hC000, 14'h0, 23'h3C000, 1'b0);
      tw(16'h8000, 8'h00); tr(16'hC000, 14'h0, 23'h3C000, 1'b0);
      tw(16'h8000, 8'h00);
      tr(16'h8000, 14'h0400, 23'h10000, 1'b1);
      tr(16'hC000, 14'h0800, 23'h14000, 1'b0);
      tr(16'hC000, 14'h0400, 23'h14000, 1'b1);
      tw(16'h8000, 8'h80);
      tr(16'hC000, 14'h0400, 23'h3C000, 1'b1);
      tr(16'h8000, 14'h0000, 23'h14000, 1'b0);

      step(16'h0000, 8'h00, 1'b1, 14'h0);
      step(16'h0000, 8'h00, 1'b1, 14'h0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         if (tbl[i].chk) begin
            expect_val($sformatf("vec%0d_prg_addr", i), S_PRG, {9'b0, tbl[i].exp_prg});
            expect_val($sformatf("vec%0d_ciram_a10", i), S_A10, {31'b0, tbl[i].exp_a10});
         end
         step(tbl[i].a, tbl[i].d, tbl[i].rw, tbl[i].pa);
      end

      // Back-to-back write pair: only the first shifts in, so six writes are needed
      wr(16'h8000, 1'b1);
      wr(16'h8000, 1'b0);
      rd(16'h0000, 14'h0);
      for (int k = 0; k < 3; k++) begin
         wr(16'h8000, 1'b1);
         rd(16'h0000, 14'h0);
      end
      expect_val("filter_not_committed", S_A10, 32'd1);
      rd(16'h0000, 14'h0400);
      wr(16'h8000, 1'b1);
      expect_val("filter_commit_a10_lo", S_A10, 32'd0);
      rd(16'h0000, 14'h0400);
      expect_val("filter_commit_a10_hi", S_A10, 32'd1);
      rd(16'h0000, 14'h0800);

      // CHR 4K mode with chr1=3
      spaced_load(16'hC000, 5'b00011);
      expect_val("chr4k_hi", S_CHR, 32'h03234);
      expect_val("chr_we_rom", S_CWE, 32'd0);
      ppu_wr = 1'b0; ppu_rd = 1'b0;
      expect_val("chr_oe", S_COE, 32'd1);
      rd(16'h0000, 14'h1234);
      ppu_wr = 1'b1; ppu_rd = 1'b1;
      expect_val("chr4k_lo", S_CHR, 32'h00234);
      rd(16'h0000, 14'h0234);
      expect_val("chr_ce_nt", S_CCE, 32'd0);
      rd(16'h0000, 14'h2000);

      // $80 after three bits discards them
      for (int k = 0; k < 3; k++) begin
         wr(16'hA000, 1'b1);
         rd(16'h0000, 14'h0);
      end
      step(16'hA000, 8'h80, 1'b0, 14'h0);
      rd(16'h0000, 14'h0);
      for (int k = 0; k < 2; k++) begin
         wr(16'hA000, 1'b0);
         rd(16'h0000, 14'h0);
      end
      expect_val("midseq_no_commit", S_CHR, 32'h00000);
      rd(16'h0000, 14'h0000);
      for (int k = 0; k < 3; k++) begin
         wr(16'hA000, k == 2);
         rd(16'h0000, 14'h0);
      end
      expect_val("midseq_chr0", S_CHR, 32'h10000);
      rd(16'h0000, 14'h0000);
      expect_val("outer_fixed", S_PRG, 32'h7C000);
      rd(16'hC000, 14'h0);
      expect_val("outer_switch", S_PRG, 32'h54000);
      expect_val("prg_oe", S_POE, 32'd1);
      rd(16'h8000, 14'h0);

      // PRG-RAM banking and write protect
      spaced_load(16'hA000, 5'b01000);
`ifdef MMC1_PRG_RAM_EN
      expect_val("ram_ce", S_RCE, 32'd1);
      expect_val("ram_we", S_RWE, 32'd1);
      expect_val("ram_addr_b2", S_RADDR, 32'h4123);
`else
      expect_val("ram_ce_off", S_RCE, 32'd0);
      expect_val("ram_we_off", S_RWE, 32'd0);
      expect_val("ram_addr_off", S_RADDR, 32'h0);
`endif
      step(16'h6123, 8'h55, 1'b0, 14'h0000);
`ifdef MMC1_PRG_RAM_EN
      expect_val("ram_addr_chr1", S_RADDR, 32'h0123);
`else
      expect_val("ram_addr_chr1_off", S_RADDR, 32'h0);
`endif
      expect_val("ram_prg_oe_low", S_POE, 32'd0);
      step(16'h6123, 8'h00, 1'b1, 14'h1000);
      spaced_load(16'hE000, 5'b10000);
      expect_val("ram_prot_ce", S_RCE, 32'd0);
      expect_val("ram_prot_we", S_RWE, 32'd0);
      step(16'h6123, 8'h55, 1'b0, 14'h0000);
      expect_val("prg_bank0", S_PRG, 32'h00000);
      rd(16'h8000, 14'h0);

      // CHR-RAM passthrough
      chr_ram = 1'b1; ppu_wr = 1'b0;
      expect_val("chrram_addr", S_CHR, 32'h01234);
      expect_val("chrram_we", S_CWE, 32'd1);
      rd(16'h0000, 14'h1234);
      chr_ram = 1'b0; ppu_wr = 1'b1;

      // Reset mid-sequence drops the partial shift
      wr(16'hE000, 1'b1);
      rd(16'h0000, 14'h0);
      reset = 1'b1;
      rd(16'h0000, 14'h0);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         wr(16'hE000, k < 2);
         rd(16'h0000, 14'h0);
      end
      expect_val("rst_partial_nocommit", S_PRG, 32'h00000);
      rd(16'h8000, 14'h0);
      wr(16'hE000, 1'b0);
      expect_val("rst_partial_commit", S_PRG, 32'h0C000);
      rd(16'h8000, 14'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule

// File: doc/mmc1_sx.md
Name: mmc1_sx

Overview:
- Parametrised MMC1-family mapper covering the SxROM board variants: SNROM, SOROM, SUROM and SXROM.
- Sits behind the mapper bus between the CPU/PPU and the PRG/CHR memories.
- Implements the 5-bit serial register load with a hardware-accurate consecutive-write filter.
- Adds PRG-ROM outer banking beyond 256 KiB and optional banked, write-protectable PRG-RAM at $6000-$7FFF.

Parameters:
ADDR_BITS, 23, width of prg_addr/chr_addr outputs
PRG_ADDR_W, 19, implemented PRG-ROM address bits (18 = 256 KiB, 19 = 512 KiB SUROM/SXROM); bits above PRG_ADDR_W-1 forced 0
CHR_ADDR_W, 17, implemented CHR address bits; bits above CHR_ADDR_W-1 forced 0
PRG_RAM_BANKS, 4, PRG-RAM 8 KiB bank count: 1, 2 or 4

Ports:
m2  in  1  CPU M2; the only clock; all registers update on its falling edge
reset  in  1  synchronous active-high reset, sampled on m2 falling edge
cpu_addr  in  16  CPU address
cpu_data_in  in  8  CPU write data
cpu_rw  in  1  1 = read, 0 = write
ppu_addr  in  14  PPU address
ppu_rd  in  1  PPU read strobe, active low
ppu_wr  in  1  PPU write strobe, active low
chr_ram  in  1  board has CHR-RAM
prg_addr  out  ADDR_BITS  PRG-ROM address
prg_oe  out  1  PRG-ROM output enable
prg_ram_ce  out  1  PRG-RAM chip enable
prg_ram_we  out  1  PRG-RAM write enable
prg_ram_addr  out  15  PRG-RAM address
chr_addr  out  ADDR_BITS  CHR address
chr_ce  out  1  CHR chip enable
chr_oe  out  1  CHR output enable
chr_we  out  1  CHR write enable
ciram_ce  out  1  CIRAM chip enable
ciram_a10  out  1  CIRAM A10

Behaviour:
- Clock and reset: single clock m2, registers on falling edge; reset is synchronous and active-high.
- Reset state: shift=5'b10000, control=5'b01100, chr0=0, chr1=0, prg=5'b00000, last_wr=0.
  - Resulting outputs: PRG mode 3, ciram_a10=0, PRG-RAM enabled.
- Register write cycle: cpu_addr[15]=1 and cpu_rw=0 on an m2 falling edge.
  - last_wr <= 1 on every register write cycle, including filtered ones; otherwise last_wr <= 0.
  - A write cycle with last_wr=1 is ignored. This is the consecutive-write filter (RMW dummy writes); only the first write of a back-to-back pair takes effect.
- Accepted write with data[7]=1: shift <= 5'b10000, control <= control | 5'b01100. Other registers are unchanged.
- Accepted write with data[7]=0: next = {data[0], shift[4:1]}.
  - If shift[0]=1: the register selected by cpu_addr[14:13] takes next. 0 = control, 1 = chr0, 2 = chr1, 3 = prg (all 5 bits). Then shift <= 5'b10000.
  - Otherwise shift <= next.
- Reset asserted mid-sequence discards the partial shift.
- Mirroring via control[1:0]:
  - 0: ciram_a10 = 0
  - 1: ciram_a10 = 1
  - 2: ciram_a10 = ppu_addr[10]
  - 3: ciram_a10 = ppu_addr[11]
- PRG bank select via control[3:2], with b = prg[3:0]:
  - 0x: {b[3:1], cpu_addr[14]}
  - 10: $8000 -> 0, $C000 -> b
  - 11: $8000 -> b, $C000 -> 4'hF
- PRG address: prg_addr = {outer, sel, cpu_addr[13:0]}.
  - outer = chr0[4] when PRG_ADDR_W=19, dropped when PRG_ADDR_W=18.
  - The outer bit applies to the fixed bank too.
  - prg_oe = cpu_rw & cpu_addr[15].
- CHR select:
  - control[4]=0: {chr0[4:1], ppu_addr[12]}
  - control[4]=1: ppu_addr[12] ? chr1 : chr0
  - chr_addr = {sel, ppu_addr[11:0]}.
  - When chr_ram=1: chr_addr = {4'b0, ppu_addr[12], ppu_addr[11:0]} and chr_we = !ppu_wr; otherwise chr_we=0.
  - ciram_ce = chr_ce = !ppu_addr[13]; chr_oe = !ppu_rd.
- All outputs are combinational from registers and current bus; a register write is visible from the next m2 low phase.
- Width rule: address bits beyond the parameterised widths are zero-filled, never wrapped.

Optional Feature:
- Macro: MMC1_PRG_RAM_EN.
- Defined:
  - ram_sel = cpu_addr[15:13]==3'b011.
  - prg_ram_ce = ram_sel & !prg[4].
  - prg_ram_we = prg_ram_ce & !cpu_rw.
  - prg_ram_addr = {bank, cpu_addr[12:0]}, where bank = chr0[3:2] (4 banks), {1'b0, chr0[3]} (2 banks) or 2'b00 (1 bank).
  - In CHR 4K mode, the bank comes from chr1 when ppu_addr[12]=1, as the latched select does.
- Undefined: prg_ram_ce=0, prg_ram_we=0, prg_ram_addr=0; prg[4] is stored but has no effect.

Test Plan:
- Reset, then CPU read $C000 -> prg_addr = {0, 4'hF, 14'h0000}; ciram_a10=0; read $8000 -> bank 0.
- Five spaced writes to $E000 of bits 1,0,1,0,0 (value 5), then read $8000 -> bank 5; shift returns to 5'b10000.
- Two writes to $8000 on consecutive m2 cycles (data 1 then 0) -> only the first shifts in; a 5-write sequence containing such a pair needs one extra write to commit.
- Mid-sequence write of $80 after three bits -> shift cleared; control[3:2]=11; the next five bits commit a fresh value.
- PRG_ADDR_W=19: chr0=5'b10000 via $A000 -> $C000 read gives prg_addr[18]=1, bank 4'hF.
- MMC1_PRG_RAM_EN, chr0=5'b01000: write $6123 -> prg_ram_ce=1, prg_ram_we=1, prg_ram_addr=15'h4123. After prg=5'b10000, the same access -> prg_ram_ce=0.
